// File: rtl/uart_pkg.sv
// uart_pkg: constants, FSM state type and frame-length helper shared by the UART
// transmitter and its transmit scheduler.
package uart_pkg;

    localparam int unsigned UART_BAUD = 115200;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} tx_state_e;

    // Twelve bit periods: the 11-bit frame plus one bit of margin, rounded up.
    function automatic int unsigned frame_cycles(input longint unsigned clk_hz, input longint unsigned baud);
        longint unsigned n;
        n = (64'd12 * clk_hz + baud - 64'd1) / baud;
        return n[31:0];
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with registered occupancy; the caller never pushes
// when full or pops when empty, and pointers wrap because DEPTH is a power of two.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     sys_clk_i,
    input  logic                     sys_rstn_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i)
        if (!sys_rstn_i) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end

    always_ff @(posedge sys_clk_i)
        if (push) mem[wp] <= wdata;

    assign rdata = mem[rp];
    assign full  = level == (AW+1)'(DEPTH);
    assign empty = level == '0;

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin merges two byte streams into a FIFO and drains it into
// the UART transmitter, pacing write strobes with a frame timer since it has no busy flag.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLOCK_HZ = 50_000_000,
    parameter int unsigned BAUD         = UART_BAUD,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rstn_i,
    input  logic                          cfg_en_i,
    input  logic                          req0_valid_i,
    input  logic [7:0]                    req0_data_i,
    output logic                          req0_ready_o,
    input  logic                          req1_valid_i,
    input  logic [7:0]                    req1_data_i,
    output logic                          req1_ready_o,
    output logic                          uart_wr_o,
    output logic [7:0]                    uart_dat_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          idle_o
);

    localparam int unsigned FRAME_CYCLES = frame_cycles(64'(SYS_CLOCK_HZ), 64'(BAUD));
    localparam int TW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e       state;
    logic [TW-1:0]   timer;
    logic            last;
    logic            full;
    logic            empty;
    logic            push0;
    logic            push1;
    logic            push;
    logic            pop;
    logic [7:0]      wdata;
    logic [7:0]      rdata;
    logic [LW-1:0]   level_nx;
    logic            idle_nx;

    // Grant goes to the requester not served last; a lone valid always wins.
    assign req0_ready_o = !full && (!req1_valid_i || last);
    assign req1_ready_o = !full && (!req0_valid_i || !last);
    assign push0        = req0_valid_i && req0_ready_o;
    assign push1        = req1_valid_i && req1_ready_o;
    assign push         = push0 || push1;
    assign wdata        = push1 ? req1_data_i : req0_data_i;
    assign pop          = state == IDLE && cfg_en_i && !empty;
    assign level_nx     = fifo_level_o + LW'(push) - LW'(pop);
    assign idle_nx      = level_nx == '0 && (state == IDLE ? !pop : state == WAIT && timer == '0);

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .sys_clk_i  (sys_clk_i),
        .sys_rstn_i (sys_rstn_i),
        .push       (push),
        .pop        (pop),
        .wdata      (wdata),
        .rdata      (rdata),
        .full       (full),
        .empty      (empty),
        .level      (fifo_level_o)
    );

    // The byte is latched on the pop, so it is stable a cycle before the strobe.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i)
        if (!sys_rstn_i) begin
            state      <= IDLE;
            timer      <= '0;
            last       <= 1'b1;
            uart_wr_o  <= 1'b0;
            uart_dat_o <= 8'h00;
            idle_o     <= 1'b1;
        end else begin
            uart_wr_o <= state == SEND;
            idle_o    <= idle_nx;
            if (push) last <= push1;
            case (state)
                IDLE: if (pop) begin
                    uart_dat_o <= rdata;
                    state      <= SEND;
                end
                SEND: begin
                    timer <= TW'(FRAME_CYCLES - 1);
                    state <= WAIT;
                end
                WAIT: if (timer == '0) state <= IDLE;
                      else timer <= timer - 1'b1;
                default: state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed stimulus with a scoreboard of expected bytes; a monitor
// checks every write strobe against it and records strobe cycles for spacing checks.
module tb_uart_tx_sched;

    logic       sys_clk_i    = 1'b0;
    logic       sys_rstn_i   = 1'b0;
    logic       cfg_en_i     = 1'b0;
    logic       req0_valid_i = 1'b0;
    logic       req1_valid_i = 1'b0;
    logic [7:0] req0_data_i  = 8'h00;
    logic [7:0] req1_data_i  = 8'h00;
    logic       req0_ready_o;
    logic       req1_ready_o;
    logic       uart_wr_o;
    logic [7:0] uart_dat_o;
    logic [4:0] fifo_level_o;
    logic       idle_o;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] sb[$];
    int         stb_q[$];
    logic       prev_wr = 1'b0;

    uart_tx_sched #(.SYS_CLOCK_HZ(1_152_000), .BAUD(115200), .FIFO_DEPTH(16)) dut (
        .sys_clk_i    (sys_clk_i),
        .sys_rstn_i   (sys_rstn_i),
        .cfg_en_i     (cfg_en_i),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .uart_wr_o    (uart_wr_o),
        .uart_dat_o   (uart_dat_o),
        .fifo_level_o (fifo_level_o),
        .idle_o       (idle_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;
    always @(posedge sys_clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int last_stb();
        return stb_q.size() != 0 ? stb_q[stb_q.size()-1] : -100000;
    endfunction

    initial begin
        forever begin
            @(posedge sys_clk_i);
            #1;
            if (uart_wr_o) begin
                stb_q.push_back(cyc);
                chk("wr_single_cycle", int'(prev_wr), 0);
                chk("strobe_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) chk("tx_data", int'(uart_dat_o), int'(sb.pop_front()));
            end
            prev_wr = uart_wr_o;
        end
    end

    // Offers a byte from the current negedge; returns at the negedge after acceptance
    // with e = index of the accepting edge. Valid is left high for the caller.
    task automatic send(input bit r, input logic [7:0] d, output int e);
        bit ok = 1'b0;
        if (r) begin req1_valid_i = 1'b1; req1_data_i = d; end
        else begin req0_valid_i = 1'b1; req0_data_i = d; end
        e = -1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            #1;
            if (r ? req1_ready_o : req0_ready_o) begin
                e  = cyc + 1;
                ok = 1'b1;
            end
            @(negedge sys_clk_i);
        end
        chk(r ? "accept_r1" : "accept_r0", int'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge sys_clk_i);
            ok = idle_o;
        end
        chk("idle_reached", int'(ok), 1);
        chk("drained", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge sys_clk_i);
        sys_rstn_i   = 1'b0;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        sb.delete();
        repeat (2) @(negedge sys_clk_i);
        sys_rstn_i = 1'b1;
    endtask

    initial begin
        int e, e0, e1, n0, n1;
        cfg_en_i = 1'b1;
        repeat (3) @(negedge sys_clk_i);
        chk("rst_wr", int'(uart_wr_o), 0);
        chk("rst_dat", int'(uart_dat_o), 8'h00);
        chk("rst_level", int'(fifo_level_o), 0);
        chk("rst_idle", int'(idle_o), 1);
        chk("rst_ready0", int'(req0_ready_o), 1);
        chk("rst_ready1", int'(req1_ready_o), 1);
        sys_rstn_i = 1'b1;
        @(negedge sys_clk_i);

        // single byte: strobe 2 edges after the push, idle 120 cycles after the strobe
        n0 = stb_q.size();
        sb.push_back(8'h41);
        send(1'b0, 8'h41, e);
        req0_valid_i = 1'b0;
        chk("single_busy", int'(idle_o), 0);
        wait_idle();
        chk("single_strobes", stb_q.size() - n0, 1);
        chk("single_latency", last_stb() - e, 2);
        chk("single_idle_gap", cyc - last_stb(), 120);

        // tie arbitration from reset: requester 0 wins first, then alternate
        do_reset();
        n0 = stb_q.size();
        sb.push_back(8'h10); sb.push_back(8'h20); sb.push_back(8'h11); sb.push_back(8'h21);
        fork
            begin send(1'b0, 8'h10, e0); send(1'b0, 8'h11, e0); req0_valid_i = 1'b0; end
            begin send(1'b1, 8'h20, e1); send(1'b1, 8'h21, e1); req1_valid_i = 1'b0; end
        join
        wait_idle();
        chk("tie_strobes", stb_q.size() - n0, 4);
        for (int k = 1; k < 4; k++)
            if (stb_q.size() > n0 + k) chk("tie_gap", stb_q[n0+k] - stb_q[n0+k-1], 122);

        // FIFO full with drain disabled; ready returns only after the pop edge
        cfg_en_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sb.push_back(8'(8'h80 + i));
            send(1'b0, 8'(8'h80 + i), e);
        end
        sb.push_back(8'h90);
        req0_data_i = 8'h90;
        #1;
        chk("full_level", int'(fifo_level_o), 16);
        chk("full_ready", int'(req0_ready_o), 0);
        cfg_en_i = 1'b1;
        #1;
        chk("full_ready_pop_cycle", int'(req0_ready_o), 0);
        @(negedge sys_clk_i);
        #1;
        chk("ready_after_pop", int'(req0_ready_o), 1);
        chk("level_after_pop", int'(fifo_level_o), 15);
        send(1'b0, 8'h90, e);
        req0_valid_i = 1'b0;
        wait_idle();

        // disable mid-frame: current frame completes, queue holds
        n0 = stb_q.size();
        sb.push_back(8'hA1);
        send(1'b0, 8'hA1, e);
        send(1'b0, 8'hA2, e);
        send(1'b0, 8'hA3, e);
        req0_valid_i = 1'b0;
        repeat (20) @(negedge sys_clk_i);
        cfg_en_i = 1'b0;
        repeat (300) @(negedge sys_clk_i);
        chk("dis_strobes", stb_q.size() - n0, 1);
        chk("dis_level", int'(fifo_level_o), 2);
        chk("dis_idle", int'(idle_o), 0);
        sb.push_back(8'hA2); sb.push_back(8'hA3);
        cfg_en_i = 1'b1;
        wait_idle();

        // push and pop in the same edge at level 1
        cfg_en_i = 1'b0;
        sb.push_back(8'hB1);
        send(1'b0, 8'hB1, e);
        req0_valid_i = 1'b0;
        @(negedge sys_clk_i);
        chk("pp_level_before", int'(fifo_level_o), 1);
        sb.push_back(8'hB2);
        cfg_en_i = 1'b1;
        send(1'b0, 8'hB2, e);
        req0_valid_i = 1'b0;
        chk("pp_level", int'(fifo_level_o), 1);
        wait_idle();

        // reset mid-WAIT with 3 bytes queued
        n0 = stb_q.size();
        sb.push_back(8'hC1);
        send(1'b0, 8'hC1, e);
        send(1'b0, 8'hC2, e);
        send(1'b0, 8'hC3, e);
        send(1'b0, 8'hC4, e);
        req0_valid_i = 1'b0;
        repeat (10) @(negedge sys_clk_i);
        chk("rstw_level", int'(fifo_level_o), 3);
        chk("rstw_strobes", stb_q.size() - n0, 1);
        #2;
        sys_rstn_i = 1'b0;
        sb.delete();
        #1;
        chk("rstw_async_wr", int'(uart_wr_o), 0);
        chk("rstw_async_dat", int'(uart_dat_o), 8'h00);
        chk("rstw_async_level", int'(fifo_level_o), 0);
        chk("rstw_async_idle", int'(idle_o), 1);
        @(negedge sys_clk_i);
        sys_rstn_i = 1'b1;
        n1 = stb_q.size();
        repeat (300) @(negedge sys_clk_i);
        chk("rstw_level_after", int'(fifo_level_o), 0);
        chk("rstw_no_strobe", stb_q.size() - n1, 0);
        sb.push_back(8'hD1);
        send(1'b0, 8'hD1, e);
        req0_valid_i = 1'b0;
        wait_idle();
        chk("rstw_new_strobe", stb_q.size() - n1, 1);

        chk("sb_final", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
